// File: rtl/mem_stage_if.sv
/******************************************************************************
 * Module      : mem_stage_if
 * Description : Stage-control, operand and result bundle between the execute
 *               stage, the memory-access stage and writeback.
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

interface mem_stage_if;
   logic [2:0]  stage;
   logic [31:0] alu_result;
   logic [31:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic [31:0] writeback_data;
   logic        mem_done;
   logic        busy;
   logic        misaligned;

   modport master (
      output stage, alu_result, write_data, mem_read, mem_write, mem_to_reg,
      input  writeback_data, mem_done, busy, misaligned
   );

   modport slave (
      input  stage, alu_result, write_data, mem_read, mem_write, mem_to_reg,
      output writeback_data, mem_done, busy, misaligned
   );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
/******************************************************************************
 * Module      : mem_stage
 * Description : Memory-access stage of the multi-cycle MIPS core. Word-addressed
 *               data memory with MEM_LATENCY-cycle load/store access.
 *               Optional alignment fault detection: MEM_STAGE_ALIGN_CHECK_EN.
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module mem_stage #(
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 2
) (
   input  wire logic   clock,
   input  wire logic   reset_n,
   mem_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] c_lat_load = 4'(MEM_LATENCY - 1);
   localparam logic [2:0] c_mem_stage = 3'd3;

   state_t              r_state;
   state_t              w_next;
   logic                r_armed;
   logic [3:0]          r_count;
   logic [31:0]         r_addr;
   logic [31:0]         r_wdata;
   logic                r_rd;
   logic                r_wr;
   logic                r_m2r;
   logic [31:0]         r_wb;
   logic                r_misaligned;
   logic [31:0]         r_mem [DEPTH];

   logic                w_trigger;
   logic                w_is_mem;
   logic                w_fault;
   logic                w_access;
   logic [ADDR_W-1:0]   w_index;

   assign w_trigger = (r_state == S_IDLE) && (bus.stage == c_mem_stage) && r_armed;
   assign w_is_mem  = bus.mem_read | bus.mem_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign w_fault = w_is_mem && (bus.alu_result[1:0] != 2'b00);
`else
   assign w_fault = 1'b0;
`endif

   // Upper address bits are dropped, so out-of-range addresses wrap.
   assign w_index  = r_addr[ADDR_W+1:2];
   assign w_access = (r_state == S_ACCESS) && (r_count == 4'd0);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_trigger) begin
               w_next = (w_is_mem && !w_fault) ? S_ACCESS : S_DONE;
            end
         end
         S_ACCESS: begin
            if (r_count == 4'd0) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_armed      <= 1'b1;
         r_count      <= 4'd0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_rd         <= 1'b0;
         r_wr         <= 1'b0;
         r_m2r        <= 1'b0;
         r_wb         <= 32'd0;
         r_misaligned <= 1'b0;
      end else begin
         r_state <= w_next;

         // One access per stage-3 entry: re-arm only once stage moves on.
         if (bus.stage != c_mem_stage) begin
            r_armed <= 1'b1;
         end else if (w_trigger) begin
            r_armed <= 1'b0;
         end

         if (w_trigger) begin
            r_addr       <= bus.alu_result;
            r_wdata      <= bus.write_data;
            r_rd         <= bus.mem_read;
            r_wr         <= bus.mem_write;
            r_m2r        <= bus.mem_to_reg;
            r_misaligned <= w_fault;
            r_count      <= c_lat_load;
            if (!w_is_mem) begin
               r_wb <= bus.alu_result;
            end else if (w_fault) begin
               r_wb <= 32'd0;
            end
         end else if (r_state == S_ACCESS) begin
            if (r_count != 4'd0) begin
               r_count <= r_count - 4'd1;
            end else if (r_wr) begin
               r_wb <= r_addr;
            end else begin
               r_wb <= (r_rd && r_m2r) ? r_mem[w_index] : r_addr;
            end
         end
      end
   end

   // Reset forces IDLE asynchronously, so an aborted access never writes.
   always_ff @(posedge clock) begin
      if (w_access && r_wr) begin
         r_mem[w_index] <= r_wdata;
      end
   end

   assign bus.writeback_data = r_wb;
   assign bus.mem_done       = (r_state == S_DONE);
   assign bus.busy           = (r_state != S_IDLE);
   assign bus.misaligned     = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
/******************************************************************************
 * Module      : tb_mem_stage
 * Description : Directed self-checking bench for mem_stage (default parameters).
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module tb_mem_stage;

   logic clock;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   mem_stage_if bus ();

   mem_stage #(
      .DEPTH       (256),
      .ADDR_W      (8),
      .MEM_LATENCY (2)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.stage      = 3'd0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
   endtask

   // Trigger one access, measure trigger-to-mem_done latency, then leave stage 3.
   task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic rd, input logic wr, input logic m2r,
                         input int exp_lat, input logic [31:0] exp_wb);
      int lat;
      bus.stage      = 3'd3;
      bus.alu_result = addr;
      bus.write_data = data;
      bus.mem_read   = rd;
      bus.mem_write  = wr;
      bus.mem_to_reg = m2r;
      tick();
      lat = 1;
      while (bus.mem_done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " wb"}, bus.writeback_data, exp_wb);
      check({tag, " busy in DONE"}, 32'(bus.busy), 32'd1);
      idle_inputs();
      tick();
      check({tag, " done is one pulse"}, 32'(bus.mem_done), 32'd0);
      check({tag, " wb holds"}, bus.writeback_data, exp_wb);
   endtask

   initial begin
      int pulses;
      int lat;
      n_checks = 0;
      n_fail   = 0;
      bus.alu_result = 32'd0;
      bus.write_data = 32'd0;
      idle_inputs();

      reset_n = 1'b0;
      tick();
      tick();
      check("reset wb", bus.writeback_data, 32'd0);
      check("reset done", 32'(bus.mem_done), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset misaligned", 32'(bus.misaligned), 32'd0);
      reset_n = 1'b1;
      tick();

      // Pass-through and store/load round trip
      run_op("pass", 32'h0000_0032, 32'h0, 1'b0, 1'b0, 1'b0, 1, 32'h32);
      run_op("sw 0x10", 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 3, 32'h10);
      run_op("lw 0x10", 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'hDEADBEEF);
      run_op("lw 0x10 no m2r", 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 3, 32'h10);

      // Wrap-around modulo DEPTH words
      run_op("sw 0x400", 32'h400, 32'h1234, 1'b0, 1'b1, 1'b0, 3, 32'h400);
      run_op("lw 0x000", 32'h000, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h1234);
      run_op("lw 0x10 intact", 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'hDEADBEEF);

      // Read and write together: write wins, ALU result returned
      run_op("rw 0x30", 32'h30, 32'h77, 1'b1, 1'b1, 1'b1, 3, 32'h30);
      run_op("lw 0x30", 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h77);

      // Stage held at 3: exactly one access
      bus.stage      = 3'd3;
      bus.alu_result = 32'h40;
      bus.write_data = 32'h1111;
      bus.mem_write  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.mem_done === 1'b1) pulses++;
         if (i == 5) bus.write_data = 32'h9999;
      end
      check("hold pulses", 32'(pulses), 32'd1);
      idle_inputs();
      bus.stage = 3'd4;
      tick();
      run_op("lw 0x40 once", 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h1111);
      run_op("sw 0x40 rearm", 32'h40, 32'h2222, 1'b0, 1'b1, 1'b0, 3, 32'h40);
      run_op("lw 0x40 rearm", 32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h2222);

      // Input changes after trigger are ignored
      bus.stage      = 3'd3;
      bus.alu_result = 32'h50;
      bus.write_data = 32'hA;
      bus.mem_write  = 1'b1;
      tick();
      bus.alu_result = 32'h60;
      bus.write_data = 32'hB;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b1;
      bus.mem_to_reg = 1'b1;
      lat = 1;
      while (bus.mem_done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("late change latency", 32'(lat), 32'd3);
      check("late change wb", bus.writeback_data, 32'h50);
      idle_inputs();
      tick();
      run_op("lw 0x50", 32'h50, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'hA);

      // Reset during ACCESS aborts the store
      run_op("sw 0x20 init", 32'h20, 32'h5555, 1'b0, 1'b1, 1'b0, 3, 32'h20);
      bus.stage      = 3'd3;
      bus.alu_result = 32'h20;
      bus.write_data = 32'hAAAA;
      bus.mem_write  = 1'b1;
      tick();
      check("abort busy before reset", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      idle_inputs();
      #1;
      check("abort wb", bus.writeback_data, 32'd0);
      check("abort done", 32'(bus.mem_done), 32'd0);
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort misaligned", 32'(bus.misaligned), 32'd0);
      tick();
      tick();
      check("abort no pulse", 32'(bus.mem_done), 32'd0);
      reset_n = 1'b1;
      tick();
      run_op("lw 0x20 after abort", 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h5555);

      // Misaligned store
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      run_op("sw 0x22", 32'h22, 32'hCAFE, 1'b0, 1'b1, 1'b0, 1, 32'h0);
      check("sw 0x22 misaligned", 32'(bus.misaligned), 32'd1);
      run_op("lw 0x20 after fault", 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'h5555);
      check("misaligned cleared", 32'(bus.misaligned), 32'd0);
`else
      run_op("sw 0x22", 32'h22, 32'hCAFE, 1'b0, 1'b1, 1'b0, 3, 32'h22);
      check("sw 0x22 misaligned", 32'(bus.misaligned), 32'd0);
      run_op("lw 0x20 after 0x22", 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 3, 32'hCAFE);
      check("misaligned stays low", 32'(bus.misaligned), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
